// File: rtl/instr_encoder_if.sv
// rtl/instr_encoder_if.sv - field-bundle in / instruction-word out bus for instr_encoder
//
// Purpose: groups the input handshake (decoded fields), the address-clear
// strobe and the output handshake (encoded word plus address) of the encoder.
//
// Signals:
//   in_valid, in_ready           input handshake
//   in_cls, in_alu               instruction class and ALU control code
//   in_rd, in_rs1, in_rs2        register indices
//   in_imm                       signed immediate / byte offset (21 bits)
//   addr_clr                     clear the word-address counter
//   out_valid, out_ready         output handshake
//   out_instr, out_addr, out_err encoded word, its word address, range error
//
// Modports: master drives fields and consumes words; slave is the encoder.

interface instr_encoder_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_cls;
  logic [2:0]        in_alu;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [20:0]       in_imm;
  logic              addr_clr;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic              out_err;

  modport master (
    output in_valid, in_cls, in_alu, in_rd, in_rs1, in_rs2, in_imm, addr_clr, out_ready,
    input  in_ready, out_valid, out_instr, out_addr, out_err
  );

  modport slave (
    input  in_valid, in_cls, in_alu, in_rd, in_rs1, in_rs2, in_imm, addr_clr, out_ready,
    output in_ready, out_valid, out_instr, out_addr, out_err
  );
endinterface

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - sequential RV32I instruction encoder with word-address counter
//
// Purpose: packs decoded fields (class, ALU op, registers, immediate) into a
// 32-bit RV32I word for six classes (R, I-ALU, LW, SW, BEQ, JAL), tags it with
// a wrapping word address and presents it through one pipeline register.
// Reserved classes produce a NOP and still consume an address.
//
// Ports:
//   clk    clock, all state on the rising edge
//   rst_n  synchronous active-low reset
//   bus    instr_encoder_if.slave (field input handshake, addr_clr, word output handshake)
//
// Optional feature: define ENC_RANGE_CHECK_EN to build the immediate range
// check that drives out_err; otherwise out_err is tied to 0.

module instr_encoder #(
  parameter int ADDR_W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  instr_encoder_if.slave bus
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [6:0] OPC_R    = 7'b0110011;
  localparam logic [6:0] OPC_I    = 7'b0010011;
  localparam logic [6:0] OPC_LW   = 7'b0000011;
  localparam logic [6:0] OPC_SW   = 7'b0100011;
  localparam logic [6:0] OPC_BEQ  = 7'b1100011;
  localparam logic [6:0] OPC_JAL  = 7'b1101111;

  logic              valid_q, valid_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  logic        in_fire;
  logic        out_fire;
  logic [2:0]  alu_f3;
  logic [6:0]  alu_f7;
  logic [31:0] enc;
  logic [20:0] imm;

  assign imm          = bus.in_imm;
  assign bus.in_ready = !valid_q | bus.out_ready;
  assign in_fire      = bus.in_valid & bus.in_ready;
  assign out_fire     = valid_q & bus.out_ready;

  // ALU code to funct3/funct7; unmapped codes fall back to ADD.
  always_comb begin
    alu_f3 = 3'b000;
    alu_f7 = 7'b0000000;
    case (bus.in_alu)
      3'b001:  alu_f7 = 7'b0100000;
      3'b010:  alu_f3 = 3'b111;
      3'b011:  alu_f3 = 3'b110;
      3'b101:  alu_f3 = 3'b010;
      default: alu_f3 = 3'b000;
    endcase
  end

  // Each class only places the fields its format uses, so unused fields are 0.
  always_comb begin
    enc = NOP;
    case (bus.in_cls)
      3'd0: enc = {alu_f7, bus.in_rs2, bus.in_rs1, alu_f3, bus.in_rd, OPC_R};
      // funct7 is dropped here, which turns SUB into ADDI.
      3'd1: enc = {imm[11:0], bus.in_rs1, alu_f3, bus.in_rd, OPC_I};
      3'd2: enc = {imm[11:0], bus.in_rs1, 3'b010, bus.in_rd, OPC_LW};
      3'd3: enc = {imm[11:5], bus.in_rs2, bus.in_rs1, 3'b010, imm[4:0], OPC_SW};
      3'd4: enc = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, 3'b000,
                   imm[4:1], imm[11], OPC_BEQ};
      3'd5: enc = {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd, OPC_JAL};
      default: enc = NOP;
    endcase
  end

`ifdef ENC_RANGE_CHECK_EN
  logic err_q, err_d;
  logic enc_err;
  logic fits12;
  logic fits13;

  // A value fits N signed bits when every bit from N-1 upward equals the sign.
  assign fits12 = (&imm[20:11]) | ~(|imm[20:11]);
  assign fits13 = (&imm[20:12]) | ~(|imm[20:12]);

  always_comb begin
    enc_err = 1'b0;
    case (bus.in_cls)
      3'd1, 3'd2, 3'd3: enc_err = !fits12;
      3'd4:             enc_err = !fits13 | imm[0];
      3'd5:             enc_err = imm[0];
      default:          enc_err = 1'b0;
    endcase
  end

  always_comb begin
    err_d = err_q;
    if (in_fire) err_d = enc_err;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign bus.out_err = err_q;
`else
  logic unused_imm0;
  assign unused_imm0 = imm[0];
  assign bus.out_err = 1'b0;
`endif

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    if (out_fire) valid_d = 1'b0;
    // A same-cycle accept overrides the drain, keeping full throughput.
    if (in_fire) begin
      valid_d = 1'b1;
      instr_d = enc;
      addr_d  = bus.addr_clr ? '0 : cnt_q;
    end
    if (bus.addr_clr) cnt_d = in_fire ? ADDR_W'(1) : '0;
    else if (in_fire) cnt_d = cnt_q + ADDR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      instr_q <= NOP;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_instr = instr_q;
  assign bus.out_addr  = addr_q;

endmodule
